// File: rtl/regbank_sb.sv
// regbank_sb: W x N register file with a busy scoreboard for long-latency ops.
//
// Two write ports and two combinational read ports:
//   port A (load/dest/inp)        single-cycle datapath result, gated by stall
//   port B (wbv/wbdest/wbdata)    long-latency writeback, never gated; clears busy
//   issue/idest                   marks the destination busy until its writeback
//   srcs/srct -> outs/outt        reads: index 0 = 0, index N-1 = cout
//   tzro/tneg                     zero / sign flags of outt
//   stall                         RAW/WAW hazard against the busy scoreboard
//   npend                         number of busy registers
//   err                           sticky: writeback to a register that was not busy
// Clock ck (rising edge), reset rb (asynchronous, active low).
//
// Optional build macro REGBANK_BYPASS_EN: forward port B write data to the
// read ports in the writeback cycle and drop the matching stall term.
// Without it, a read of a register under writeback stalls one extra cycle.

// One writable register plus its busy bit.
module regbank_sb_entry #(
  parameter int W = 32
) (
  input  logic         ck,
  input  logic         rb,
  input  logic         wea,   // port A write (already stall-gated)
  input  logic [W-1:0] da,
  input  logic         web,   // port B write
  input  logic [W-1:0] db,
  input  logic         setb,  // issue to this index (already stall-gated)
  output logic [W-1:0] q,
  output logic         busy
);
  // Port A can only collide with port B when this entry is not busy
  // (otherwise A is stalled); in that case the writeback wins.
  always_ff @(posedge ck or negedge rb)
    if (!rb)      q <= '0;
    else if (web) q <= db;
    else if (wea) q <= da;

  // A new issue in the same cycle as a writeback only gets here when the
  // entry is idle (a busy entry stalls the issue), so the new pending op wins.
  always_ff @(posedge ck or negedge rb)
    if (!rb)       busy <= 1'b0;
    else if (setb) busy <= 1'b1;
    else if (web)  busy <= 1'b0;
endmodule

module regbank_sb #(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          ck,
  input  logic          rb,
  input  logic          load,
  input  logic [AW-1:0] dest,
  input  logic [W-1:0]  inp,
  input  logic          issue,
  input  logic [AW-1:0] idest,
  input  logic          wbv,
  input  logic [AW-1:0] wbdest,
  input  logic [W-1:0]  wbdata,
  input  logic [AW-1:0] srcs,
  input  logic [AW-1:0] srct,
  input  logic [W-1:0]  cout,
  output logic [W-1:0]  outs,
  output logic [W-1:0]  outt,
  output logic          tzro,
  output logic          tneg,
  output logic          stall,
  output logic [AW:0]   npend,
  output logic          err
);
  localparam logic [AW-1:0] TOP = AW'(N-1);

  logic [N-1:0][W-1:0] rf;
  logic [N-1:0]        busy;
  logic                wbok;
  logic                fwds, fwdt;

  // Fixed ends of the file: never stored, never busy.
  assign rf[0]     = '0;
  assign rf[N-1]   = cout;
  assign busy[0]   = 1'b0;
  assign busy[N-1] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < N-1; g++) begin : g_ent
      regbank_sb_entry #(.W(W)) u_ent (
        .ck   (ck),
        .rb   (rb),
        .wea  (load & ~stall & (dest == AW'(g))),
        .da   (inp),
        .web  (wbv & (wbdest == AW'(g))),
        .db   (wbdata),
        .setb (issue & ~stall & (idest == AW'(g))),
        .q    (rf[g]),
        .busy (busy[g])
      );
    end
  endgenerate

  assign wbok = wbv & (wbdest != '0) & (wbdest != TOP);

`ifdef REGBANK_BYPASS_EN
  assign fwds = wbok & (wbdest == srcs);
  assign fwdt = wbok & (wbdest == srct);
`else
  assign fwds = 1'b0;
  assign fwdt = 1'b0;
`endif

  assign outs = fwds ? wbdata : rf[srcs];
  assign outt = fwdt ? wbdata : rf[srct];
  assign tzro = (outt == '0);
  assign tneg = outt[W-1];

  assign stall = (busy[srcs] & ~fwds) | (busy[srct] & ~fwdt) |
                 (load & busy[dest]) | (issue & busy[idest]);

  always_comb begin
    npend = '0;
    for (int i = 0; i < N; i++)
      npend = npend + {{AW{1'b0}}, busy[i]};
  end

  // The write itself still happens; only the flag records the orphan writeback.
  always_ff @(posedge ck or negedge rb)
    if (!rb)                      err <= 1'b0;
    else if (wbok & ~busy[wbdest]) err <= 1'b1;
endmodule

// File: tb/tb_regbank_sb.sv
module tb_regbank_sb;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = $clog2(N);
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          ck, rb;
  logic          load, issue, wbv;
  logic [AW-1:0] dest, idest, wbdest, srcs, srct;
  logic [W-1:0]  inp, wbdata, cout;
  logic [W-1:0]  outs, outt;
  logic          tzro, tneg, stall, err;
  logic [AW:0]   npend;

  int compared = 0;
  int mismatched = 0;

  regbank_sb #(.W(W), .N(N)) dut (
    .ck(ck), .rb(rb), .load(load), .dest(dest), .inp(inp),
    .issue(issue), .idest(idest), .wbv(wbv), .wbdest(wbdest), .wbdata(wbdata),
    .srcs(srcs), .srct(srct), .cout(cout),
    .outs(outs), .outt(outt), .tzro(tzro), .tneg(tneg),
    .stall(stall), .npend(npend), .err(err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference model: plain arrays following the behavioural rules.
  logic [W-1:0] mem [N];
  bit           mbusy [N];
  bit           merr;

  function automatic bit wr(input int i);
    return (i != 0) && (i != N-1);
  endfunction

  function automatic logic [W-1:0] rd(input int i);
    if (i == 0)   return '0;
    if (i == N-1) return cout;
    return mem[i];
  endfunction

  function automatic bit fwd(input int i);
    return BYP && wbv && (int'(wbdest) == i) && wr(int'(wbdest));
  endfunction

  function automatic logic [W-1:0] e_outs();
    return fwd(int'(srcs)) ? wbdata : rd(int'(srcs));
  endfunction

  function automatic logic [W-1:0] e_outt();
    return fwd(int'(srct)) ? wbdata : rd(int'(srct));
  endfunction

  function automatic bit e_stall();
    return (mbusy[srcs] && !fwd(int'(srcs))) || (mbusy[srct] && !fwd(int'(srct))) ||
           (load && mbusy[dest]) || (issue && mbusy[idest]);
  endfunction

  function automatic int e_npend();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mem[i] = '0;
      mbusy[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] et;
    et = e_outt();
    chk({tag, ".outs"},  outs, e_outs());
    chk({tag, ".outt"},  outt, et);
    chk({tag, ".tzro"},  W'(tzro), W'(et == '0));
    chk({tag, ".tneg"},  W'(tneg), W'(et[W-1]));
    chk({tag, ".stall"}, W'(stall), W'(e_stall()));
    chk({tag, ".npend"}, W'(npend), W'(e_npend()));
    chk({tag, ".err"},   W'(err), W'(merr));
  endtask

  task automatic idle();
    load = 0; issue = 0; wbv = 0;
    dest = '0; idest = '0; wbdest = '0; srcs = '0; srct = '0;
    inp = '0; wbdata = '0;
  endtask

  // Advance one rising edge, update the model with the inputs held across it.
  task automatic tick();
    bit st;
    st = e_stall();
    @(posedge ck);
    if (load && !st && wr(int'(dest))) mem[dest] = inp;
    if (wbv && wr(int'(wbdest))) begin
      if (!mbusy[wbdest]) merr = 1'b1;
      mem[wbdest] = wbdata;
      mbusy[wbdest] = 1'b0;
    end
    if (issue && !st && wr(int'(idest))) mbusy[idest] = 1'b1;
    #1;
  endtask

  initial begin
    int pick;
    int bl [$];

    // Reset state, with index N-1 visible through cout.
    idle(); cout = 32'h1234_5678; srct = AW'(N-1);
    rb = 1'b0; model_reset();
    #2 check_all("reset");
    chk("reset.outt_cout", outt, 32'h1234_5678);
    @(negedge ck) rb = 1'b1;
    #1;

    // Port A write then read back.
    idle(); load = 1; dest = 3; inp = 32'hDEADBEEF;
    #1 check_all("wr3"); tick();
    idle(); srcs = 3; srct = 0;
    #1 check_all("rd3");
    chk("rd3.outs", outs, 32'hDEADBEEF);
    chk("rd3.tzro", W'(tzro), 32'd1);

    // Writes to the fixed ends are ignored.
    idle(); load = 1; dest = 0; inp = 5; tick();
    idle(); load = 1; dest = AW'(N-1); inp = 5; tick();
    idle(); srcs = 0; srct = AW'(N-1); cout = 32'h8000_0001;
    #1 check_all("ends");
    chk("ends.outs", outs, 32'h0);
    chk("ends.outt", outt, 32'h8000_0001);
    chk("ends.tneg", W'(tneg), 32'd1);

    // Issue / RAW stall / writeback.
    idle(); issue = 1; idest = 5; tick();
    idle(); srcs = 5;
    #1 check_all("busy5");
    chk("busy5.npend", W'(npend), 32'd1);
    chk("busy5.stall", W'(stall), 32'd1);
    wbv = 1; wbdest = 5; wbdata = 42;
    #1 check_all("wb5");
    chk("wb5.stall", W'(stall), BYP ? 32'd0 : 32'd1);
    tick();
    idle(); srcs = 5;
    #1 check_all("after_wb5");
    chk("after_wb5.outs", outs, 32'd42);
    chk("after_wb5.npend", W'(npend), 32'd0);

    // WAW: load and re-issue against a busy register.
    idle(); issue = 1; idest = 7; tick();
    idle(); load = 1; dest = 7; inp = 1;
    #1 check_all("waw_load");
    chk("waw_load.stall", W'(stall), 32'd1);
    tick();
    idle(); issue = 1; idest = 7;
    #1 check_all("waw_issue");
    chk("waw_issue.stall", W'(stall), 32'd1);
    tick();
    idle(); srct = 7;
    #1 check_all("reg7");
    chk("reg7.outt", outt, 32'd0);
    chk("reg7.npend", W'(npend), 32'd1);

    // Orphan writeback sets the sticky error.
    idle(); wbv = 1; wbdest = 9; wbdata = 99; tick();
    idle(); srcs = 9;
    for (int i = 0; i < 10; i++) begin
      #1 check_all("err_hold"); tick();
    end
    chk("err_hold.err", W'(err), 32'd1);
    chk("err_hold.outs", outs, 32'd99);
    rb = 1'b0; model_reset();
    #1 check_all("err_rst");
    chk("err_rst.err", W'(err), 32'd0);
    @(negedge ck) rb = 1'b1;
    #1;

    // Asynchronous reset in the middle of a pending op.
    idle(); issue = 1; idest = 4; tick();
    idle();
    #2 rb = 1'b0; model_reset();
    #1 check_all("async_rst");
    chk("async_rst.npend", W'(npend), 32'd0);
    @(negedge ck) rb = 1'b1;
    #1;
    idle(); wbv = 1; wbdest = 4; wbdata = 7; tick();
    idle();
    #1 check_all("post_rst_wb");
    chk("post_rst_wb.err", W'(err), 32'd1);

    // Randomized traffic against the model.
    rb = 1'b0; model_reset();
    @(negedge ck) rb = 1'b1;
    #1;
    for (int c = 0; c < 400; c++) begin
      load   = ($urandom_range(0, 1) == 1);
      dest   = AW'($urandom_range(0, N-1));
      inp    = $urandom;
      issue  = ($urandom_range(0, 9) < 3);
      idest  = AW'($urandom_range(0, N-1));
      wbv    = ($urandom_range(0, 9) < 4);
      bl.delete();
      for (int i = 0; i < N; i++) if (mbusy[i]) bl.push_back(i);
      if (bl.size() > 0 && $urandom_range(0, 9) < 8) begin
        pick = int'($urandom_range(0, bl.size() - 1));
        wbdest = AW'(bl[pick]);
      end else
        wbdest = AW'($urandom_range(0, N-1));
      wbdata = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      srcs   = AW'($urandom_range(0, N-1));
      srct   = ($urandom_range(0, 3) == 0) ? wbdest : AW'($urandom_range(0, N-1));
      cout   = $urandom;
      #1 check_all("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
